// File: rtl/partial_sum_pkg.sv
// Shared types and width helpers for the partial-sum accumulator.
// Widths are sized so a full group never overflows the output word.
package partial_sum_pkg;

  typedef enum logic {
    PS_UNSIGNED = 1'b0,
    PS_SIGNED   = 1'b1
  } ps_mode_e;

  typedef struct packed {
    logic first;
    logic last;
  } beat_tag_t;

  function automatic int calc_out_w(
    input int in_w,
    input int macro_num,
    input int acc_num_max
  );
    return in_w + $clog2(macro_num) + $clog2(acc_num_max);
  endfunction

  function automatic int calc_cnt_w(input int acc_num_max);
    return $clog2(acc_num_max) + 1;
  endfunction

endpackage

// File: rtl/partial_sum_acc_adder_tree.sv
// Per-channel macro reduction with mode-aware extension.
// Purely combinational; the parent registers the result.
module ps_adder_tree
  import partial_sum_pkg::*;
#(
  parameter int MACRO_NUM = 4,
  parameter int IN_W      = 4,
  parameter int OUT_W     = 10
) (
  input  ps_mode_e                  mode,
  input  logic [MACRO_NUM*IN_W-1:0] din,
  output logic [OUT_W-1:0]          sum
);

  logic [IN_W-1:0]  v;
  logic [OUT_W-1:0] ext;
  logic             sx;

  always_comb begin
    sum = '0;
    v   = '0;
    ext = '0;
    sx  = 1'b0;
    for (int m = 0; m < MACRO_NUM; m++) begin
      v   = din[m*IN_W +: IN_W];
      sx  = (mode == PS_SIGNED) && v[IN_W-1];
      ext = {{(OUT_W-IN_W){sx}}, v};
      sum = sum + ext;
    end
  end

endmodule

// File: rtl/partial_sum_acc.sv
// Two-stage partial-sum accumulator: S1 reduces macros per channel,
// S2 accumulates over a group of beats and holds the result for handoff.
module partial_sum_acc
  import partial_sum_pkg::*;
#(
  parameter  int CHANNEL_NUM = 128,
  parameter  int MACRO_NUM   = 4,
  parameter  int IN_W        = 4,
  parameter  int ACC_NUM_MAX = 16,
  localparam int OUT_W = calc_out_w(IN_W, MACRO_NUM, ACC_NUM_MAX),
  localparam int CNT_W = calc_cnt_w(ACC_NUM_MAX)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               signed_mode,
  input  logic [CNT_W-1:0]                   acc_num,
  input  logic                               acc_clr,
  input  logic                               data_in_valid,
  output logic                               data_in_ready,
  input  logic [CHANNEL_NUM*MACRO_NUM*IN_W-1:0] data_in,
  output logic                               data_out_valid,
  input  logic                               data_out_ready,
  output logic [CHANNEL_NUM*OUT_W-1:0]       data_out
);

  localparam int CH_IN_W = MACRO_NUM * IN_W;
  localparam logic [CNT_W-1:0] NUM_MAX = CNT_W'(ACC_NUM_MAX);

  logic                         en;
  logic                         fire;
  logic                         start;
  logic                         s2_go;
  logic [CNT_W-1:0]             cnt_q;
  logic [CNT_W-1:0]             cnt_cur;
  logic [CNT_W-1:0]             num_q;
  logic [CNT_W-1:0]             num_in;
  logic [CNT_W-1:0]             num_cur;
  ps_mode_e                     mode_q;
  ps_mode_e                     mode_cur;
  beat_tag_t                    tag;
  beat_tag_t                    s1_tag;
  logic                         s1_valid;
  logic [CHANNEL_NUM*OUT_W-1:0] sum_d;
  logic [CHANNEL_NUM*OUT_W-1:0] sum_q;
  logic [CHANNEL_NUM*OUT_W-1:0] acc_d;
  logic [CHANNEL_NUM*OUT_W-1:0] acc_q;

  assign en            = !data_out_valid || data_out_ready;
  assign data_in_ready = en;
  assign fire          = data_in_valid && en;

  // A clear coinciding with a beat makes that beat the first of a new group.
  assign start   = acc_clr || (cnt_q == '0);
  assign cnt_cur = acc_clr ? '0 : cnt_q;

  always_comb begin
    num_in = acc_num;
    if (acc_num == '0) begin
      num_in = CNT_W'(1);
    end else if (acc_num > NUM_MAX) begin
      num_in = NUM_MAX;
    end
  end

  assign num_cur  = start ? num_in : num_q;
  assign mode_cur = start ? (signed_mode ? PS_SIGNED : PS_UNSIGNED)
                          : mode_q;

  assign tag = '{first: start,
                 last:  (cnt_cur == num_cur - CNT_W'(1))};

  assign s2_go = en && s1_valid && !acc_clr;

  for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_ch
    ps_adder_tree #(
      .MACRO_NUM (MACRO_NUM),
      .IN_W      (IN_W),
      .OUT_W     (OUT_W)
    ) u_tree (
      .mode (mode_cur),
      .din  (data_in[c*CH_IN_W +: CH_IN_W]),
      .sum  (sum_d[c*OUT_W +: OUT_W])
    );

    assign acc_d[c*OUT_W +: OUT_W] =
      (s1_tag.first ? '0 : acc_q[c*OUT_W +: OUT_W])
      + sum_q[c*OUT_W +: OUT_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      num_q          <= CNT_W'(1);
      mode_q         <= PS_UNSIGNED;
      s1_valid       <= 1'b0;
      s1_tag         <= '0;
      sum_q          <= '0;
      acc_q          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      if (fire) begin
        cnt_q  <= tag.last ? '0 : cnt_cur + CNT_W'(1);
        num_q  <= num_cur;
        mode_q <= mode_cur;
        sum_q  <= sum_d;
        s1_tag <= tag;
      end else if (acc_clr) begin
        cnt_q <= '0;
      end

      if (en || acc_clr) begin
        s1_valid <= fire;
      end

      if (acc_clr) begin
        acc_q <= '0;
      end else if (s2_go) begin
        acc_q <= s1_tag.last ? '0 : acc_d;
      end

      if (s2_go && s1_tag.last) begin
        data_out       <= acc_d;
        data_out_valid <= 1'b1;
      end else if (data_out_valid && data_out_ready) begin
        data_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_partial_sum_acc.sv
// Randomized bench for partial_sum_acc against a beat/group-level model,
// plus directed groups with hand-computed literal results.
module tb_partial_sum_acc;
  import partial_sum_pkg::*;

  localparam int CH    = 128;
  localparam int M     = 4;
  localparam int IN_W  = 4;
  localparam int AMAX  = 16;
  localparam int OUT_W = calc_out_w(IN_W, M, AMAX);
  localparam int CNT_W = calc_cnt_w(AMAX);
  localparam int DW    = CH * OUT_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    signed_mode;
  logic [CNT_W-1:0]        acc_num;
  logic                    acc_clr;
  logic                    data_in_valid;
  logic                    data_in_ready;
  logic [CH*M*IN_W-1:0]    data_in;
  logic                    data_out_valid;
  logic                    data_out_ready;
  logic [DW-1:0]           data_out;

  logic [IN_W-1:0] din [CH][M];

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  logic [DW-1:0] last_out = '0;

  logic [DW-1:0] exp_q[$];
  int  g_cnt = 0;
  int  g_num = 1;
  bit  g_sgn = 1'b0;
  int  g_acc [CH];

  partial_sum_acc #(
    .CHANNEL_NUM (CH),
    .MACRO_NUM   (M),
    .IN_W        (IN_W),
    .ACC_NUM_MAX (AMAX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .signed_mode    (signed_mode),
    .acc_num        (acc_num),
    .acc_clr        (acc_clr),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (data_in_ready),
    .data_in        (data_in),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .data_out       (data_out)
  );

  always #5 clk = ~clk;

  always_comb begin
    data_in = '0;
    for (int c = 0; c < CH; c++)
      for (int m = 0; m < M; m++)
        data_in[(c*M+m)*IN_W +: IN_W] = din[c][m];
  end

  function automatic logic [31:0] ch(input logic [DW-1:0] v, input int c);
    return 32'(v[c*OUT_W +: OUT_W]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_beat();
    logic [DW-1:0] ev;
    int sv;
    if (g_cnt == 0) begin
      g_num = (acc_num == 0) ? 1 : int'(acc_num);
      if (g_num > AMAX) g_num = AMAX;
      g_sgn = signed_mode;
      for (int c = 0; c < CH; c++) g_acc[c] = 0;
    end
    for (int c = 0; c < CH; c++)
      for (int m = 0; m < M; m++) begin
        sv = int'(din[c][m]);
        if (g_sgn && din[c][m][IN_W-1]) sv -= (1 << IN_W);
        g_acc[c] += sv;
      end
    g_cnt++;
    if (g_cnt == g_num) begin
      ev = '0;
      for (int c = 0; c < CH; c++) ev[c*OUT_W +: OUT_W] = OUT_W'(g_acc[c]);
      exp_q.push_back(ev);
      g_cnt = 0;
    end
  endtask

  // Compare process: checks every handoff and every stalled cycle.
  initial begin : monitor
    bit held = 1'b0;
    logic [DW-1:0] held_val = '0;
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (held) begin
        checks++;
        if (!(data_out_valid === 1'b1 && data_out === held_val)) begin
          failures++;
          $display("FAIL hold_stable: valid %0b ch0 %0h expected ch0 %0h",
                   data_out_valid, ch(data_out, 0), ch(held_val, 0));
        end
      end
      if (rst) begin
        held = 1'b0;
        exp_q.delete();
        g_cnt = 0;
      end else begin
        chk("in_ready", 32'(data_in_ready),
            32'(!data_out_valid || data_out_ready));
        held     = data_out_valid && !data_out_ready;
        held_val = data_out;
        if (data_out_valid && data_out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out: ch0 %0h expected none",
                     ch(data_out, 0));
          end else begin
            e = exp_q.pop_front();
            if (data_out !== e) begin
              failures++;
              for (int c = 0; c < CH; c++)
                if (ch(data_out, c) !== ch(e, c)) begin
                  $display("FAIL out_data: ch %0d got %0h expected %0h",
                           c, ch(data_out, c), ch(e, c));
                  break;
                end
            end
          end
          n_out++;
          last_out = data_out;
        end
        if (acc_clr) g_cnt = 0;
        if (data_in_valid && data_in_ready) model_beat();
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill(input int v);
    for (int c = 0; c < CH; c++)
      for (int m = 0; m < M; m++) din[c][m] = IN_W'(v);
  endtask

  task automatic rnd_din();
    for (int c = 0; c < CH; c++)
      for (int m = 0; m < M; m++) din[c][m] = IN_W'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input bit keep, input bit rnd);
    int n = 0;
    data_in_valid = 1'b1;
    forever begin
      if (rnd) data_out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (data_in_ready) break;
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout: ready 0 after %0d cycles", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!keep) data_in_valid = 1'b0;
  endtask

  initial begin : stim
    int n0;
    rst = 1'b1;
    signed_mode = 1'b0;
    acc_num = CNT_W'(1);
    acc_clr = 1'b0;
    data_in_valid = 1'b0;
    data_out_ready = 1'b1;
    fill(0);
    idle(3);
    @(negedge clk);
    chk("rst_valid", 32'(data_out_valid), 0);
    chk("rst_data", 32'(|data_out), 0);
    chk("rst_in_ready", 32'(data_in_ready), 1);
    idle(1);
    rst = 1'b0;

    // unsigned, one beat per group, all 4'hF
    fill(15);
    n0 = n_out;
    push_beat(0, 0);
    @(negedge clk);
    chk("t1_lat1", 32'(data_out_valid), 0);
    @(negedge clk);
    chk("t1_lat2", 32'(data_out_valid), 1);
    chk("t1_first", ch(data_out, 0), 60);
    idle(1);
    repeat (4) push_beat(1, 0);
    data_in_valid = 1'b0;
    idle(4);
    chk("t1_count", 32'(n_out - n0), 5);
    chk("t1_last", ch(last_out, CH-1), 60);

    // signed, three beats of -8
    signed_mode = 1'b1;
    acc_num = CNT_W'(3);
    fill(8);
    n0 = n_out;
    repeat (3) push_beat(1, 0);
    data_in_valid = 1'b0;
    idle(5);
    chk("t2_count", 32'(n_out - n0), 1);
    chk("t2_val", ch(last_out, 0), 32'h3A0);

    // full-length unsigned group at maximum value
    signed_mode = 1'b0;
    acc_num = CNT_W'(16);
    fill(15);
    n0 = n_out;
    repeat (16) push_beat(1, 0);
    data_in_valid = 1'b0;
    idle(5);
    chk("t3_count", 32'(n_out - n0), 1);
    chk("t3_val", ch(last_out, 5), 960);

    // acc_num=0 acts as 1
    acc_num = '0;
    n0 = n_out;
    repeat (2) push_beat(0, 0);
    idle(5);
    chk("t6_num0_count", 32'(n_out - n0), 2);
    chk("t6_num0_val", ch(last_out, 0), 60);

    // mode change mid-group is ignored until the next group
    acc_num = CNT_W'(2);
    signed_mode = 1'b0;
    fill(8);
    n0 = n_out;
    push_beat(1, 0);
    signed_mode = 1'b1;
    push_beat(0, 0);
    idle(5);
    chk("t6_mode_count", 32'(n_out - n0), 1);
    chk("t6_mode_val", ch(last_out, 0), 64);
    acc_num = CNT_W'(1);
    push_beat(0, 0);
    idle(5);
    chk("t6_mode_next", ch(last_out, 0), 32'h3E0);

    // clear alone, then clear with a coincident beat
    signed_mode = 1'b0;
    acc_num = CNT_W'(4);
    fill(1);
    n0 = n_out;
    repeat (2) push_beat(0, 0);
    idle(1);
    acc_clr = 1'b1;
    idle(1);
    acc_clr = 1'b0;
    repeat (2) push_beat(0, 0);
    fill(2);
    acc_clr = 1'b1;
    push_beat(0, 0);
    acc_clr = 1'b0;
    fill(1);
    repeat (3) push_beat(0, 0);
    idle(5);
    chk("t5_count", 32'(n_out - n0), 1);
    chk("t5_val", ch(last_out, 77), 20);

    // backpressure with a pending result
    data_out_ready = 1'b0;
    acc_num = CNT_W'(1);
    fill(5);
    n0 = n_out;
    push_beat(0, 0);
    idle(2);
    @(negedge clk);
    chk("t4_valid", 32'(data_out_valid), 1);
    chk("t4_stall", 32'(data_in_ready), 0);
    idle(1);
    fill(7);
    data_in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall_in", 32'(data_in_ready), 0);
    end
    idle(1);
    data_out_ready = 1'b1;
    push_beat(0, 0);
    idle(4);
    chk("t4_count", 32'(n_out - n0), 2);
    chk("t4_val", ch(last_out, 0), 28);

    // randomized traffic
    n0 = n_out;
    for (int i = 0; i < 1000; i++) begin
      signed_mode = 1'($urandom_range(0, 1));
      acc_num = CNT_W'($urandom_range(0, 16));
      rnd_din();
      push_beat($urandom_range(0, 3) != 0, 1);
      if (!data_in_valid)
        repeat ($urandom_range(0, 2)) begin
          data_out_ready = ($urandom_range(0, 3) != 0);
          idle(1);
        end
    end
    data_in_valid = 1'b0;
    data_out_ready = 1'b1;
    idle(8);
    chk("rand_drain", 32'(exp_q.size()), 0);
    chk("rand_some", 32'((n_out - n0) > 50), 1);

    // reset mid-group with a held result
    acc_clr = 1'b1;
    idle(1);
    acc_clr = 1'b0;
    data_out_ready = 1'b0;
    signed_mode = 1'b0;
    acc_num = CNT_W'(1);
    fill(1);
    push_beat(0, 0);
    acc_num = CNT_W'(3);
    push_beat(0, 0);
    idle(1);
    @(negedge clk);
    chk("t6_pre_rst_valid", 32'(data_out_valid), 1);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t6_rst_valid", 32'(data_out_valid), 0);
    chk("t6_rst_data", 32'(|data_out), 0);
    chk("t6_rst_in_ready", 32'(data_in_ready), 1);
    idle(1);
    rst = 1'b0;
    data_out_ready = 1'b1;
    acc_num = CNT_W'(1);
    fill(3);
    n0 = n_out;
    push_beat(0, 0);
    idle(4);
    chk("t6_after_count", 32'(n_out - n0), 1);
    chk("t6_after_val", ch(last_out, 0), 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
